// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx : parallel-in / serial-out frame transmitter
//
// Accepts a WIDTH-bit word over a valid/ready handshake and sends it on a
// single wire as: start bit (0), data bits LSB first, optional even-parity
// bit, stop bit (1). Every serial bit is held for CLKS_PER_BIT clocks. The
// line idles at 1.
//
// Optional feature:
//   PISO_TX_PARITY_EN - when defined, a PARITY bit (XOR of the latched word)
//                       is sent between the last data bit and the stop bit.
//                       When undefined there is no parity state or logic.
//
// Parameters:
//   WIDTH        - data word width, 1..32
//   CLKS_PER_BIT - clocks per serial bit, >= 1
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   in_data  in   [WIDTH] word to send, sampled on handshake only
//   in_valid in   producer has a word
//   in_ready out  transmitter is idle and can take a word (combinational)
//   sd       out  serial data line, registered, idle high
//   busy     out  frame in progress, registered with the state
//   done     out  one-clock pulse on the first idle cycle after a frame
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sd,
    output logic             busy,
    output logic             done
);

    // Counter widths never collapse to zero, even for single-clock bits or
    // single-bit words.
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PISO_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [DIV_W-1:0]   div;
    logic [DIV_W-1:0]   div_nx;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   bit_idx_nx;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_nx;
`ifdef PISO_TX_PARITY_EN
    logic               par;
    logic               par_nx;
`endif

    logic               sd_nx;
    logic               busy_nx;
    logic               done_nx;

    logic               accept;
    logic               bit_tick;
    logic               last_bit;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    // bit_tick marks the last clock of the current serial bit.
    assign bit_tick = (div == DIV_LAST);
    assign last_bit = (bit_idx == IDX_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick && last_bit) begin
`ifdef PISO_TX_PARITY_EN
                    state_nx = S_PARITY;
`else
                    state_nx = S_STOP;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    state_nx = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values: divider, bit index, shift register, parity
    // -------------------------------------------------------------------------
    always_comb begin
        div_nx     = div;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
`ifdef PISO_TX_PARITY_EN
        par_nx     = par;
`endif
        if (state == S_IDLE) begin
            if (accept) begin
                div_nx     = '0;
                bit_idx_nx = '0;
                shreg_nx   = in_data;
`ifdef PISO_TX_PARITY_EN
                par_nx     = ^in_data;
`endif
            end
        end else begin
            div_nx = bit_tick ? '0 : (div + DIV_ONE);
            // The word shifts right at each data-bit boundary so bit 0 of the
            // register is always the bit currently on the line.
            if ((state == S_DATA) && bit_tick) begin
                shreg_nx   = shreg >> 1;
                bit_idx_nx = last_bit ? '0 : (bit_idx + IDX_ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef PISO_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            div     <= div_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
`ifdef PISO_TX_PARITY_EN
            par     <= par_nx;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // sd is registered from the *next* state and shift-register contents so
    // the line value lands in the same cycle as the state it belongs to; this
    // puts the start bit on the line one clock after the handshake edge.
    always_comb begin
        sd_nx   = 1'b1;
        busy_nx = (state_nx != S_IDLE);
        done_nx = (state == S_STOP) && (state_nx == S_IDLE);
        case (state_nx)
            S_START:  sd_nx = 1'b0;
            S_DATA:   sd_nx = shreg_nx[0];
`ifdef PISO_TX_PARITY_EN
            S_PARITY: sd_nx = par_nx;
`endif
            default:  sd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sd   <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            sd   <= sd_nx;
            busy <= busy_nx;
            done <= done_nx;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx : bench for piso_tx
//
// Two instances: (WIDTH=8, CLKS_PER_BIT=4) and (WIDTH=4, CLKS_PER_BIT=1).
// A timeline model tracks, per instance, how many clocks have passed since
// the last accepted word and derives the expected line, busy, done and ready
// from the frame bit list. A compare process checks every cycle; directed
// sequences add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_piso_tx;

    localparam int W0 = 8;
    localparam int C0 = 4;
    localparam int W1 = 4;
    localparam int C1 = 1;
`ifdef PISO_TX_PARITY_EN
    localparam int PB = 1;
    localparam int EXP_A5   = 1354;
    localparam int EXP_81   = 1282;
    localparam int EXP_1001 = 82;
`else
    localparam int PB = 0;
    localparam int EXP_A5   = 842;
    localparam int EXP_81   = 770;
    localparam int EXP_1001 = 50;
`endif
    localparam int NB0 = W0 + 2 + PB;
    localparam int NB1 = W1 + 2 + PB;
    localparam int F0  = NB0 * C0;
    localparam int F1  = NB1 * C1;
    localparam int IDLE_T = 1000;
    localparam logic [15:0] MASK0 = 16'((1 << NB0) - 1);
    localparam logic [15:0] MASK1 = 16'((1 << NB1) - 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v0 = 1'b0;
    logic [7:0] d0 = '0;
    logic       v1 = 1'b0;
    logic [3:0] d1 = '0;
    logic       r0, sd0, b0, dn0;
    logic       r1, sd1, b1, dn1;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W0), .CLKS_PER_BIT(C0)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(d0), .in_valid(v0),
        .in_ready(r0), .sd(sd0), .busy(b0), .done(dn0)
    );

    piso_tx #(.WIDTH(W1), .CLKS_PER_BIT(C1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1),
        .in_ready(r1), .sd(sd1), .busy(b1), .done(dn1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame as a bit list: [0]=start, [1..w]=data LSB first, then parity, stop.
    function automatic logic [33:0] mkframe(input int w, input logic [31:0] d);
        logic [33:0] f;
        logic        p;
        f = '0;
        p = 1'b0;
        for (int i = 0; i < w; i++) begin
            f[i+1] = d[i];
            p      = p ^ d[i];
        end
`ifdef PISO_TX_PARITY_EN
        f[w+1] = p;
        f[w+2] = 1'b1;
`else
        f[w+1] = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic in_frame(input int t, input int fr);
        return (t >= 1) && (t <= fr);
    endfunction

    // t = clocks since the accepting edge (1 = first cycle of the start bit).
    int          t0 = IDLE_T;
    int          t1 = IDLE_T;
    logic [33:0] fb0 = '0;
    logic [33:0] fb1 = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t0 <= IDLE_T;
            t1 <= IDLE_T;
        end else begin
            if (v0 && !in_frame(t0, F0)) begin
                t0  <= 1;
                fb0 <= mkframe(W0, {24'd0, d0});
            end else if (t0 < IDLE_T) begin
                t0 <= t0 + 1;
            end
            if (v1 && !in_frame(t1, F1)) begin
                t1  <= 1;
                fb1 <= mkframe(W1, {28'd0, d1});
            end else if (t1 < IDLE_T) begin
                t1 <= t1 + 1;
            end
        end
    end

    task automatic check_one(input string n, input int t, input int fr, input int c,
                             input logic [33:0] fb, input logic s, input logic b,
                             input logic d, input logic r);
        logic eb, es;
        eb = in_frame(t, fr);
        es = eb ? fb[(t-1)/c] : 1'b1;
        check({n, ".sd"},    32'(s), 32'(es));
        check({n, ".busy"},  32'(b), 32'(eb));
        check({n, ".done"},  32'(d), 32'(t == fr + 1));
        check({n, ".ready"}, 32'(r), 32'(!eb));
    endtask

    always @(negedge clk) begin
        check_one("dut0", t0, F0, C0, fb0, sd0, b0, dn0, r0);
        check_one("dut1", t1, F1, C1, fb1, sd1, b1, dn1, r1);
    end

    // ---------------- directed helpers ----------------
    // Returns 2 time units after the accepting edge.
    task automatic send0(input logic [7:0] d);
        int n;
        @(posedge clk); #2;
        v0 = 1'b1;
        d0 = d;
        n  = 0;
        while (!r0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send0_timeout", 0, 1);
        @(posedge clk); #2;
        v0 = 1'b0;
    endtask

    task automatic send1(input logic [3:0] d);
        int n;
        @(posedge clk); #2;
        v1 = 1'b1;
        d1 = d;
        n  = 0;
        while (!r1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send1_timeout", 0, 1);
        @(posedge clk); #2;
        v1 = 1'b0;
    endtask

    // Sample the middle of each bit, count busy cycles, find the done cycle.
    task automatic collect0(output logic [15:0] seq, output int bc, output int dk);
        seq = '0;
        bc  = 0;
        dk  = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (((k - 1) % C0) == (C0 / 2) && ((k - 1) / C0) < 16) seq[(k-1)/C0] = sd0;
            if (b0) bc++;
            if (dn0 && dk == 0) dk = k;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] seq;
        int          bc, dk, k, run, nd, dk1, dk2;
        logic        q [0:127];

        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Reset then idle
        repeat (10) @(negedge clk);
        check("idle_sd",    32'(sd0), 1);
        check("idle_ready", 32'(r0),  1);
        check("idle_busy",  32'(b0),  0);
        check("idle_done",  32'(dn0), 0);

        // Model pinned by hand-computed frames
        check("model_a5",   32'(mkframe(W0, 32'hA5) & 34'(MASK0)), EXP_A5);
        check("model_1001", 32'(mkframe(W1, 32'h9)  & 34'(MASK1)), EXP_1001);

        // Single frame 8'hA5
        send0(8'hA5);
        collect0(seq, bc, dk);
        check("a5_bits", 32'(seq & MASK0), EXP_A5);
        check("a5_busy_clocks", bc, F0);
        check("a5_done_at", dk, F0 + 1);

        // Back-to-back 8'h00 then 8'hFF with valid held
        @(posedge clk); #2;
        v0 = 1'b1;
        d0 = 8'h00;
        @(posedge clk); #2;
        d0 = 8'hFF;
        nd = 0; dk1 = 0; dk2 = 0;
        for (int i = 1; i < 128; i++) begin
            @(negedge clk);
            q[i] = sd0;
            if (dn0) begin
                nd++;
                if (nd == 1) dk1 = i;
                if (nd == 2) dk2 = i;
                if (nd == 1) begin
                    @(posedge clk); #2;
                    v0 = 1'b0;
                end
            end
        end
        k = 1;
        while (k < 128 && q[k] == 1'b0) k++;
        run = 0;
        while (k < 128 && q[k] == 1'b1) begin
            run++;
            k++;
        end
        check("b2b_done_count", nd, 2);
        check("b2b_first_done", dk1, F0 + 1);
        check("b2b_done_spacing", dk2 - dk1, F0 + 1);
        check("b2b_gap", run, C0 + 1);

        // Reset mid-frame during data bit 3 of 8'h3C
        send0(8'h3C);
        repeat (4 * C0 + 2) @(negedge clk);
        check("pre_reset_busy", 32'(b0), 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_sd",    32'(sd0), 1);
        check("async_reset_busy",  32'(b0),  0);
        check("async_reset_ready", 32'(r0),  1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        send0(8'h81);
        collect0(seq, bc, dk);
        check("post_reset_81_bits", 32'(seq & MASK0), EXP_81);
        check("post_reset_81_done", dk, F0 + 1);

        // WIDTH=4, CLKS_PER_BIT=1, 4'b1001
        send1(4'b1001);
        seq = '0;
        dk  = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            seq[i-1] = sd1;
            if (dn1 && dk == 0) dk = i;
        end
        check("w4_bits", 32'(seq & MASK1), EXP_1001);
        check("w4_done_at", dk, F1 + 1);

        // Randomized traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            v0 = ($urandom_range(0, 2) == 0);
            d0 = 8'($urandom);
            v1 = ($urandom_range(0, 2) == 0);
            d1 = 4'($urandom);
        end
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (F0 + 10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in/serial-out frame transmitter; produces the single-bit serial data stream captured downstream by the team's D-flop/shift-register receive path.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it on one wire:
  - start bit 0,
  - data LSB first,
  - stop bit 1.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between a word producer (FIFO or bench) and a serial sink.

Parameters:
- WIDTH, 8: data word width in bits; legal range 1..32.
- CLKS_PER_BIT, 4: clocks each serial bit is held; legal minimum 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  WIDTH  word to transmit; sampled only on handshake.
- in_valid  input  1  producer has a word.
- in_ready  output  1  transmitter can accept a word.
- sd  output  1  serial data line, registered; idle level 1.
- busy  output  1  frame in progress (any state but IDLE).
- done  output  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (reset=0, async): state=IDLE, sd=1, busy=0, done=0, shift register and counters cleared, in_ready=1 (in_ready = state==IDLE).
  - Reset mid-frame aborts the frame immediately; sd returns to 1 without waiting for clk.
- Handshake:
  - Transfer occurs on a rising edge with in_valid=1 and in_ready=1; in_data is latched into the shift register.
  - in_ready is 0 in every state but IDLE.
  - in_data/in_valid changes while busy are ignored.
  - in_valid held without in_ready is not an error.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: sd=1. On handshake go to START.
  - START: sd=0 for CLKS_PER_BIT clocks, beginning the cycle after the handshake edge.
  - DATA: WIDTH bits, LSB first, each for CLKS_PER_BIT clocks.
    - Shift register shifts right at each bit boundary.
    - Bit index counts 0..WIDTH-1.
  - STOP: sd=1 for CLKS_PER_BIT clocks, then go to IDLE.
    - done=1 for exactly the first cycle in IDLE.
- Counters:
  - Divider counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - CLKS_PER_BIT=1 gives one bit per clock with no dead cycles.
  - Bit counter wraps to 0 on leaving DATA.
- Latency: sd goes low 1 clock after the handshake edge.
  - Without parity, the frame occupies (WIDTH+2)*CLKS_PER_BIT clocks.
  - done occurs (WIDTH+2)*CLKS_PER_BIT+1 clocks after the handshake edge.
- Back-to-back: with in_valid held, the next handshake happens on the IDLE/done cycle.
  - Line stays 1 for CLKS_PER_BIT+1 clocks between frames (stop plus one idle cycle); this is the guaranteed minimum inter-frame gap.
- Simultaneous events:
  - done and the next handshake may coincide; both are honoured.
  - Reset overrides everything.
- busy = (state != IDLE); registered with the state.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - sd carries the even-parity bit (XOR of the latched word) for CLKS_PER_BIT clocks.
  - Frame becomes (WIDTH+3)*CLKS_PER_BIT clocks; done timing shifts accordingly.
  - Parity is computed from the word latched at handshake.
- Not defined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset then idle: reset=0 for 2 clocks, release, no in_valid for 10 clocks -> sd=1, in_ready=1, busy=0, done=0 throughout.
- Single frame (WIDTH=8, CLKS_PER_BIT=4), in_data=8'hA5 for one handshake:
  - sd = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 clocks.
  - busy=1 for 40 clocks.
  - done pulses once, 41 clocks after the handshake edge.
- Back-to-back: in_valid held with 8'h00 then 8'hFF -> second start bit begins exactly 5 clocks after the first stop bit starts (4 stop + 1 idle); two done pulses, 41 clocks apart.
- Parity (PISO_TX_PARITY_EN defined): 8'hA5 gives parity bit 0; 8'h07 gives parity bit 1 -> frame 44 clocks; parity bit lies between the last data bit and the stop bit.
- Reset mid-frame: assert reset during data bit 3 of 8'h3C, asynchronously to clk -> sd=1 and busy=0 immediately; after release, in_ready=1 and a new 8'h81 frame transmits correctly with no residue.
- CLKS_PER_BIT=1, WIDTH=4, in_data=4'b1001 -> sd = 0,1,0,0,1,1 on consecutive clocks; done 7 clocks after the handshake edge.
